// File: rtl/wbuf_sched_pkg.sv
// rtl/wbuf_sched_pkg.sv - shared state encoding and loop-width default for the wbuf_send scheduler
package wbuf_sched_pkg;

  localparam int LW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_S,
    ST_WAIT_E,
    ST_DONE
  } state_t;

endpackage

// File: rtl/wbuf_sched_if.sv
// rtl/wbuf_sched_if.sv - requester/engine signal bundle between PE-group controllers, scheduler and wbuf_send
interface wbuf_sched_if
  import wbuf_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LW    = LW_DEF
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*LW-1:0] req_loop;
  logic                wbuf_en;
  logic                wbuf_send;
  logic [LW-1:0]       loop;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                busy;
  logic                err;

  modport master (
    output req, req_loop, wbuf_en,
    input  wbuf_send, loop, gnt, done, busy, err
  );

  modport slave (
    input  req, req_loop, wbuf_en,
    output wbuf_send, loop, gnt, done, busy, err
  );

endinterface

// File: rtl/wbuf_sched_rr_pick.sv
// rtl/wbuf_sched_rr_pick.sv - combinational round-robin select: first set req at or after ptr, wrapping
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    sel   = '0;
    any   = |req;
    found = 1'b0;
    idx   = '0;
    // modulo N rather than bit-wrap so non-power-of-two N never selects a missing port
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbuf_sched.sv
// rtl/wbuf_sched.sv - round-robin scheduler sharing one wbuf_send engine among N_REQ requesters
module wbuf_sched
  import wbuf_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int LW       = LW_DEF,
  parameter int START_TO = 8
) (
  input  logic         clk,
  input  logic         rst,
  wbuf_sched_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(START_TO) + 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state, state_nxt;
  logic [PW-1:0]    sel, ptr, pick_sel;
  logic             pick_any;
  logic [LW-1:0]    pick_loop;
  logic [TW-1:0]    to_cnt;

  logic             send_nxt, err_nxt;
  logic [LW-1:0]    loop_nxt;
  logic [N_REQ-1:0] gnt_nxt, done_nxt;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

  assign pick_loop = bus.req_loop[int'(pick_sel)*LW +: LW];

  // Outputs are computed one cycle ahead and registered, so send/gnt line up with entry to ISSUE.
  always_comb begin
    state_nxt = state;
    send_nxt  = 1'b0;
    loop_nxt  = '0;
    gnt_nxt   = bus.gnt;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nxt = ONE << pick_sel;
          if (pick_loop == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ISSUE;
            send_nxt  = 1'b1;
            loop_nxt  = pick_loop;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_S;
      ST_WAIT_S: begin
        if (bus.wbuf_en) begin
          state_nxt = ST_WAIT_E;
        end else if (to_cnt == TW'(START_TO - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_WAIT_E: begin
        if (!bus.wbuf_en) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        done_nxt  = ONE << sel;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sel           <= '0;
      ptr           <= '0;
      to_cnt        <= '0;
      bus.wbuf_send <= 1'b0;
      bus.loop      <= '0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.wbuf_send <= send_nxt;
      bus.loop      <= loop_nxt;
      bus.gnt       <= gnt_nxt;
      bus.done      <= done_nxt;
      bus.busy      <= (state_nxt != ST_IDLE);
      bus.err       <= err_nxt;
      if (state == ST_IDLE && pick_any) sel <= pick_sel;
      if (state == ST_ISSUE) begin
        to_cnt <= '0;
      end else if (state == ST_WAIT_S) begin
        to_cnt <= to_cnt + TW'(1);
      end
      // the requester just served drops to lowest priority
      if (state == ST_DONE) ptr <= (sel == PW'(N_REQ - 1)) ? '0 : sel + PW'(1);
    end
  end

endmodule

// File: tb/tb_wbuf_sched.sv
// tb/tb_wbuf_sched.sv - scoreboard bench for wbuf_sched with a behavioural wbuf_send engine
module tb_wbuf_sched;

  localparam int K_GNT  = 0;
  localparam int K_SEND = 1;
  localparam int K_ERR  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int val;
    int aux;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stub_dead;
  logic [7:0] mcnt;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int c0, c1;
  exp_t sb[$];
  logic [3:0] prev_gnt = '0;

  wbuf_sched_if #(.N_REQ(4), .LW(8)) bus ();

  wbuf_sched #(.N_REQ(4), .LW(8), .START_TO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model: busy for exactly loop cycles starting the cycle after the send pulse
  always @(posedge clk) begin
    if (rst) begin
      bus.wbuf_en <= 1'b0;
      mcnt        <= '0;
    end else if (bus.wbuf_send && !stub_dead) begin
      bus.wbuf_en <= 1'b1;
      mcnt        <= bus.loop;
    end else if (bus.wbuf_en) begin
      if (mcnt == 8'd1) bus.wbuf_en <= 1'b0;
      mcnt <= mcnt - 8'd1;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int k, input int v, input int a, input int c);
    sb.push_back('{k, v, a, c});
  endtask

  task automatic check_evt(input int k, input int v, input int a);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL evt_unexpected: got kind=%0d val=%0d aux=%0d cyc=%0d required no event", k, v, a, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v || e.aux != a || e.cyc != cyc) begin
        fails++;
        $display("FAIL evt: got kind=%0d val=%0d aux=%0d cyc=%0d required kind=%0d val=%0d aux=%0d cyc=%0d",
                 k, v, a, cyc, e.kind, e.val, e.aux, e.cyc);
      end
    end
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic set_loop(input int i, input int v);
    bus.req_loop[i*8 +: 8] = 8'(v);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        tests++;
        if (!$onehot0(bus.gnt) || (!bus.wbuf_send && bus.loop != 8'd0)) begin
          fails++;
          $display("FAIL invariant: got gnt=%b send=%0d loop=%0d required onehot0 gnt, loop 0 when idle",
                   bus.gnt, bus.wbuf_send, bus.loop);
        end
        if (bus.gnt != 4'd0 && prev_gnt == 4'd0) check_evt(K_GNT, int'(bus.gnt), 0);
        if (bus.wbuf_send) check_evt(K_SEND, int'(bus.gnt), int'(bus.loop));
        if (bus.err) check_evt(K_ERR, 0, 0);
        if (bus.done != 4'd0) check_evt(K_DONE, int'(bus.done), int'(bus.gnt) * 2 + int'(bus.busy));
      end
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    rst          = 1'b1;
    stub_dead    = 1'b0;
    bus.req      = '0;
    bus.req_loop = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_send", int'(bus.wbuf_send), 0);
    chk("rst_loop", int'(bus.loop), 0);
    chk("rst_gnt",  int'(bus.gnt), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err",  int'(bus.err), 0);
    @(posedge clk);
    #1;

    // single request; loop change after the sample must not leak through
    c0 = cyc;
    set_loop(0, 5);
    bus.req = 4'b0001;
    push(K_GNT, 1, 0, c0 + 1);
    push(K_SEND, 1, 5, c0 + 1);
    push(K_DONE, 1, 0, c0 + 9);
    to_cyc(c0 + 1);
    bus.req = 4'b0000;
    set_loop(0, 9);
    to_cyc(c0 + 12);
    drain("single_drain");

    rst = 1'b1;
    to_cyc(cyc + 2);
    rst = 1'b0;
    to_cyc(cyc + 1);

    // all four requesting: served 0,1,2,3,0
    c0 = cyc;
    set_loop(0, 1);
    set_loop(1, 2);
    set_loop(2, 3);
    set_loop(3, 4);
    bus.req = 4'b1111;
    push(K_GNT, 1, 0, c0 + 1);  push(K_SEND, 1, 1, c0 + 1);  push(K_DONE, 1, 0, c0 + 5);
    push(K_GNT, 2, 0, c0 + 6);  push(K_SEND, 2, 2, c0 + 6);  push(K_DONE, 2, 0, c0 + 11);
    push(K_GNT, 4, 0, c0 + 12); push(K_SEND, 4, 3, c0 + 12); push(K_DONE, 4, 0, c0 + 18);
    push(K_GNT, 8, 0, c0 + 19); push(K_SEND, 8, 4, c0 + 19); push(K_DONE, 8, 0, c0 + 26);
    push(K_GNT, 1, 0, c0 + 27); push(K_SEND, 1, 1, c0 + 27); push(K_DONE, 1, 0, c0 + 31);
    to_cyc(c0 + 27);
    bus.req = 4'b0000;
    to_cyc(c0 + 34);
    drain("rr_drain");

    // zero loop: grant then done, never a send
    c0 = cyc;
    set_loop(2, 0);
    bus.req = 4'b0100;
    push(K_GNT, 4, 0, c0 + 1);
    push(K_DONE, 4, 0, c0 + 2);
    to_cyc(c0 + 1);
    bus.req = 4'b0000;
    to_cyc(c0 + 5);
    drain("zero_drain");

    // one-cycle request still completes; later request waits for DONE
    c0 = cyc;
    set_loop(3, 2);
    bus.req = 4'b1000;
    push(K_GNT, 8, 0, c0 + 1);
    push(K_SEND, 8, 2, c0 + 1);
    push(K_DONE, 8, 0, c0 + 6);
    to_cyc(c0 + 1);
    bus.req = 4'b0000;
    to_cyc(c0 + 3);
    set_loop(0, 3);
    bus.req = 4'b0001;
    push(K_GNT, 1, 0, c0 + 7);
    push(K_SEND, 1, 3, c0 + 7);
    push(K_DONE, 1, 0, c0 + 13);
    to_cyc(c0 + 7);
    bus.req = 4'b0000;
    to_cyc(c0 + 16);
    drain("drop_drain");

    // engine never starts: ERR after 8 WAIT_S cycles, DONE the cycle after
    stub_dead = 1'b1;
    c0 = cyc;
    set_loop(1, 3);
    bus.req = 4'b0010;
    push(K_GNT, 2, 0, c0 + 1);
    push(K_SEND, 2, 3, c0 + 1);
    push(K_ERR, 0, 0, c0 + 10);
    push(K_DONE, 2, 0, c0 + 11);
    to_cyc(c0 + 1);
    bus.req = 4'b0000;
    to_cyc(c0 + 14);
    drain("timeout_drain");
    stub_dead = 1'b0;

    // reset during WAIT_E: no DONE, pointer back to 0
    c0 = cyc;
    set_loop(2, 5);
    bus.req = 4'b0100;
    push(K_GNT, 4, 0, c0 + 1);
    push(K_SEND, 4, 5, c0 + 1);
    to_cyc(c0 + 1);
    bus.req = 4'b0000;
    to_cyc(c0 + 4);
    rst = 1'b1;
    to_cyc(c0 + 5);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_send", int'(bus.wbuf_send), 0);
    chk("mid_rst_loop", int'(bus.loop), 0);
    chk("mid_rst_gnt",  int'(bus.gnt), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_err",  int'(bus.err), 0);
    to_cyc(c0 + 8);
    c1 = cyc;
    set_loop(0, 2);
    set_loop(3, 1);
    bus.req = 4'b1001;
    push(K_GNT, 1, 0, c1 + 1);
    push(K_SEND, 1, 2, c1 + 1);
    push(K_DONE, 1, 0, c1 + 6);
    to_cyc(c1 + 1);
    bus.req = 4'b0000;
    to_cyc(c1 + 9);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
